// File: rtl/soc_clk_rst_status.sv
`default_nettype none
// ============================================================================
// Module      : soc_clk_rst_status
// Description : Board-level clock divider, stretched SoC reset sequencer,
//               lockup fault latch/counter with debounced clear, and
//               two-colour status LED with dimmable heartbeat.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_clk_rst_status #(
  parameter int CLK_DIV      = 2,
  parameter int RST_STRETCH  = 16,
  parameter int HB_COUNT_MSB = 26,
  parameter int DIM_BITS     = 6,
  parameter int HB_DUTY      = 1,
  parameter int DEB_CYCLES   = 1000000,
  parameter int CNT_W        = 8
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Lockup,
  input  logic             ClearFault,
  output logic             HCLK,
  output logic             HRESETn,
  output logic             Status_Green,
  output logic             Status_Red,
  output logic [CNT_W-1:0] FaultCount
);

  localparam int c_half_div = CLK_DIV / 2;
  localparam int c_div_w    = (c_half_div > 1) ? $clog2(c_half_div) : 1;
  localparam int c_st_w     = $clog2(RST_STRETCH + 1);
  localparam int c_deb_w    = $clog2(DEB_CYCLES + 1);

  localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(c_half_div - 1);
  localparam logic [c_st_w-1:0]   c_st_max   = c_st_w'(RST_STRETCH);
  localparam logic [c_deb_w-1:0]  c_deb_max  = c_deb_w'(DEB_CYCLES);
  localparam logic [c_deb_w-1:0]  c_deb_last = c_deb_w'(DEB_CYCLES - 1);
  localparam logic [DIM_BITS:0]   c_duty     = (DIM_BITS + 1)'(HB_DUTY);
  localparam logic [CNT_W-1:0]    c_cnt_max  = '1;

  logic [c_div_w-1:0]    r_div_cnt;
  logic                  r_hclk;
  logic                  r_rst_meta;
  logic                  r_rst_sync;
  logic [c_st_w-1:0]     r_stretch;
  logic                  r_hresetn;
  logic                  r_running;
  logic [HB_COUNT_MSB:0] r_tick;
  logic                  r_hb;
  logic                  r_lk_meta;
  logic                  r_lk_s;
  logic                  r_lk_d;
  logic                  r_cf_meta;
  logic                  r_cf_s;
  logic [c_deb_w-1:0]    r_deb_cnt;
  logic                  r_clr_pulse;
  logic                  r_fault;
  logic [CNT_W-1:0]      r_fault_cnt;
  logic                  r_green;
  logic                  r_red;

  logic w_div_wrap;
  logic w_lk_rise;
  logic w_hb_on;

  assign w_div_wrap = (r_div_cnt == c_div_last);
  assign w_lk_rise  = r_lk_s & ~r_lk_d;
  assign w_hb_on    = r_tick[HB_COUNT_MSB] & r_tick[HB_COUNT_MSB-2] &
                      ({1'b0, r_tick[DIM_BITS-1:0]} < c_duty);

  // Half-period counter; HCLK toggles each time it wraps
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_div_cnt <= '0;
      r_hclk    <= 1'b0;
    end else if (w_div_wrap) begin
      r_div_cnt <= '0;
      r_hclk    <= ~r_hclk;
    end else begin
      r_div_cnt <= r_div_cnt + c_div_w'(1);
    end
  end

  // Synchronise reset release, stretch it, then release HRESETn on an HCLK fall
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
      r_stretch  <= '0;
      r_hresetn  <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
      if (r_rst_sync && (r_stretch != c_st_max))
        r_stretch <= r_stretch + c_st_w'(1);
      if ((r_stretch == c_st_max) && w_div_wrap && r_hclk)
        r_hresetn <= 1'b1;
      r_running  <= r_hresetn;
    end
  end

  // Free-running tick counter and registered heartbeat PWM
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_tick <= '0;
      r_hb   <= 1'b0;
    end else begin
      if (r_running)
        r_tick <= r_tick + (HB_COUNT_MSB + 1)'(1);
      r_hb <= w_hb_on;
    end
  end

  // Lockup synchroniser plus delayed copy for rising-edge detection
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_lk_meta <= 1'b0;
      r_lk_s    <= 1'b0;
      r_lk_d    <= 1'b0;
    end else begin
      r_lk_meta <= Lockup;
      r_lk_s    <= r_lk_meta;
      r_lk_d    <= r_lk_s;
    end
  end

  // Button debounce: one clear pulse per stable press, re-armed by release
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_cf_meta   <= 1'b0;
      r_cf_s      <= 1'b0;
      r_deb_cnt   <= '0;
      r_clr_pulse <= 1'b0;
    end else begin
      r_cf_meta   <= ClearFault;
      r_cf_s      <= r_cf_meta;
      if (!r_cf_s)
        r_deb_cnt <= '0;
      else if (r_deb_cnt != c_deb_max)
        r_deb_cnt <= r_deb_cnt + c_deb_w'(1);
      r_clr_pulse <= r_cf_s && (r_deb_cnt == c_deb_last);
    end
  end

  // Fault latch and saturating counter; a new lockup edge beats a clear
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_fault     <= 1'b0;
      r_fault_cnt <= '0;
    end else if (w_lk_rise) begin
      r_fault <= 1'b1;
      if (r_fault_cnt != c_cnt_max)
        r_fault_cnt <= r_fault_cnt + CNT_W'(1);
    end else if (r_clr_pulse && !r_lk_s) begin
      r_fault     <= 1'b0;
      r_fault_cnt <= '0;
    end
  end

  // Registered LED colour by priority: booting, live lockup, latched fault, heartbeat
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_green <= 1'b1;
      r_red   <= 1'b1;
    end else if (!r_running) begin
      r_green <= 1'b1;
      r_red   <= 1'b1;
    end else if (r_lk_s) begin
      r_green <= 1'b0;
      r_red   <= 1'b1;
    end else if (r_fault) begin
      r_green <= 1'b0;
      r_red   <= r_tick[HB_COUNT_MSB];
    end else begin
      r_green <= r_hb;
      r_red   <= 1'b0;
    end
  end

  assign HCLK         = r_hclk;
  assign HRESETn      = r_hresetn;
  assign Status_Green = r_green;
  assign Status_Red   = r_red;
  assign FaultCount   = r_fault_cnt;

endmodule
`default_nettype wire

// File: tb/tb_soc_clk_rst_status.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_clk_rst_status
// Description : Directed self-checking bench for soc_clk_rst_status. A second
//               instance with a 2-bit fault counter covers saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_clk_rst_status;

  logic       Clock;
  logic       nReset;
  logic       Lockup;
  logic       ClearFault;
  logic       HCLK;
  logic       HRESETn;
  logic       Status_Green;
  logic       Status_Red;
  logic [7:0] FaultCount;
  logic       hclk_sat;
  logic       hresetn_sat;
  logic       green_sat;
  logic       red_sat;
  logic [1:0] fault_count_sat;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  soc_clk_rst_status #(
    .CLK_DIV(4), .RST_STRETCH(8), .HB_COUNT_MSB(5), .DIM_BITS(2),
    .HB_DUTY(1), .DEB_CYCLES(4), .CNT_W(8)
  ) u_dut (
    .Clock(Clock), .nReset(nReset), .Lockup(Lockup), .ClearFault(ClearFault),
    .HCLK(HCLK), .HRESETn(HRESETn), .Status_Green(Status_Green),
    .Status_Red(Status_Red), .FaultCount(FaultCount)
  );

  soc_clk_rst_status #(
    .CLK_DIV(4), .RST_STRETCH(8), .HB_COUNT_MSB(5), .DIM_BITS(2),
    .HB_DUTY(1), .DEB_CYCLES(4), .CNT_W(2)
  ) u_dut_sat (
    .Clock(Clock), .nReset(nReset), .Lockup(Lockup), .ClearFault(ClearFault),
    .HCLK(hclk_sat), .HRESETn(hresetn_sat), .Status_Green(green_sat),
    .Status_Red(red_sat), .FaultCount(fault_count_sat)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Clock edges since the last reset release
  always @(posedge Clock or negedge nReset) begin
    if (!nReset) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed timeout, required completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, required %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // tick after edge k is k-13; green after edge k reflects tick at k-2
  function automatic logic [1:0] exp_hb_led(input int k);
    logic [5:0] t;
    t = 6'((k - 15) & 63);
    return {t[5] & t[3] & (t[1:0] == 2'd0), 1'b0};
  endfunction

  // red blink after edge k reflects tick[5] at edge k-1
  function automatic logic [1:0] exp_blink_led(input int k);
    logic [5:0] t;
    t = 6'((k - 14) & 63);
    return {1'b0, t[5]};
  endfunction

  task automatic boot_checks();
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clock);
      case (k)
        1:  check_val("boot_hclk_e1", HCLK, 1'b0);
        2:  check_val("boot_hclk_e2", HCLK, 1'b1);
        4:  check_val("boot_hclk_e4", HCLK, 1'b0);
        6:  check_val("boot_hclk_e6", HCLK, 1'b1);
        11: begin
              check_val("boot_hresetn_e11", HRESETn, 1'b0);
              check_val("boot_led_e11", {Status_Green, Status_Red}, 2'b11);
            end
        12: begin
              check_val("boot_hresetn_e12", HRESETn, 1'b1);
              check_val("boot_hclk_e12", HCLK, 1'b0);
            end
        13: check_val("boot_led_e13", {Status_Green, Status_Red}, 2'b11);
        14: check_val("boot_led_e14", {Status_Green, Status_Red}, 2'b00);
        default: ;
      endcase
    end
  endtask

  task automatic lockup_pulse();
    Lockup = 1'b1;
    repeat (3) @(negedge Clock);
    Lockup = 1'b0;
    repeat (5) @(negedge Clock);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_hclk"}, HCLK, 1'b0);
    check_val({tag, "_hresetn"}, HRESETn, 1'b0);
    check_val({tag, "_cnt"}, FaultCount, 8'd0);
    check_val({tag, "_cnt_sat"}, fault_count_sat, 2'd0);
    check_val({tag, "_led"}, {Status_Green, Status_Red}, 2'b11);
  endtask

  initial begin
    int guard;
    Lockup     = 1'b0;
    ClearFault = 1'b0;
    nReset     = 1'b1;
    #1 nReset  = 1'b0;
    repeat (3) @(negedge Clock);
    check_reset_state("reset");

    // Release and boot sequence
    nReset = 1'b1;
    boot_checks();

    // Heartbeat over two full tick wraps
    repeat (128) begin
      @(negedge Clock);
      check_val("hb_led", {Status_Green, Status_Red}, exp_hb_led(cyc));
    end

    // First lockup: solid red while held, then blinking red
    Lockup = 1'b1;
    repeat (10) @(negedge Clock);
    check_val("lk_solid_led", {Status_Green, Status_Red}, 2'b01);
    Lockup = 1'b0;
    repeat (4) @(negedge Clock);
    check_val("lk_cnt1", FaultCount, 8'd1);
    repeat (40) begin
      @(negedge Clock);
      check_val("lk_blink_led", {Status_Green, Status_Red}, exp_blink_led(cyc));
    end

    // Three more edges, then a fifth to saturate the narrow counter
    repeat (3) lockup_pulse();
    check_val("lk_cnt4", FaultCount, 8'd4);
    check_val("lk_cnt4_sat", fault_count_sat, 2'd3);
    lockup_pulse();
    check_val("lk_cnt5", FaultCount, 8'd5);
    check_val("lk_cnt5_sat", fault_count_sat, 2'd3);

    // Too-short press is ignored
    ClearFault = 1'b1;
    repeat (3) @(negedge Clock);
    ClearFault = 1'b0;
    repeat (8) @(negedge Clock);
    check_val("short_press_cnt", FaultCount, 8'd5);
    check_val("short_press_cnt_sat", fault_count_sat, 2'd3);
    check_val("short_press_led", {Status_Green, Status_Red}, exp_blink_led(cyc));

    // Stable press clears the fault; heartbeat resumes
    ClearFault = 1'b1;
    repeat (6) @(negedge Clock);
    ClearFault = 1'b0;
    repeat (4) @(negedge Clock);
    check_val("clear_cnt", FaultCount, 8'd0);
    check_val("clear_cnt_sat", fault_count_sat, 2'd0);
    repeat (70) begin
      @(negedge Clock);
      check_val("clear_hb_led", {Status_Green, Status_Red}, exp_hb_led(cyc));
    end

    // Press while Lockup is still asserted is ignored
    Lockup = 1'b1;
    repeat (5) @(negedge Clock);
    check_val("held_cnt_before", FaultCount, 8'd1);
    ClearFault = 1'b1;
    repeat (6) @(negedge Clock);
    ClearFault = 1'b0;
    repeat (4) @(negedge Clock);
    check_val("held_cnt_after", FaultCount, 8'd1);
    check_val("held_cnt_after_sat", fault_count_sat, 2'd1);
    check_val("held_led", {Status_Green, Status_Red}, 2'b01);
    Lockup = 1'b0;
    repeat (6) @(negedge Clock);
    check_val("held_release_led", {Status_Green, Status_Red}, exp_blink_led(cyc));

    // Lockup edge lands in the same cycle as the clear pulse
    ClearFault = 1'b1;
    repeat (4) @(negedge Clock);
    Lockup = 1'b1;
    repeat (2) @(negedge Clock);
    ClearFault = 1'b0;
    repeat (2) @(negedge Clock);
    Lockup = 1'b0;
    repeat (6) @(negedge Clock);
    check_val("coinc_cnt", FaultCount, 8'd2);
    check_val("coinc_cnt_sat", fault_count_sat, 2'd2);
    check_val("coinc_led", {Status_Green, Status_Red}, exp_blink_led(cyc));

    // Mid-run reset while HCLK is high and a fault is latched
    guard = 0;
    do begin
      @(negedge Clock);
      guard++;
    end while ((cyc % 4 != 2) && (guard < 8));
    check_val("pre_rst_hclk", HCLK, 1'b1);
    check_val("pre_rst_hresetn", HRESETn, 1'b1);
    #2 nReset = 1'b0;
    #1 check_reset_state("midrst");
    repeat (3) @(negedge Clock);
    nReset = 1'b1;
    boot_checks();
    check_val("reboot_cnt", FaultCount, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/soc_clk_rst_status.md
Name: soc_clk_rst_status

Overview:
Board-level clock, reset and status controller for the M0 AHB-Lite SoC, replacing the fixed divide-by-2 and hard-wired reset logic in the FPGA wrapper.
- Derives HCLK from the board clock with a parametrised even divider.
- Produces a synchronised, stretched HRESETn.
- Latches and counts processor lockup events, clearable by a debounced button.
- Drives a two-colour status LED with dimmable heartbeat and fault indication.

Parameters:
CLK_DIV, 2, Clock cycles per HCLK period; even, >=2.
RST_STRETCH, 16, Clock cycles HRESETn is held low after synchronised nReset release; >=1.
HB_COUNT_MSB, 26, MSB index of heartbeat tick counter; >=2.
DIM_BITS, 6, width of heartbeat PWM field; PWM compare uses tick[DIM_BITS-1:0]; DIM_BITS <= HB_COUNT_MSB-2.
HB_DUTY, 1, heartbeat PWM on-count per 2^DIM_BITS ticks; 0..2^DIM_BITS.
DEB_CYCLES, 1000000, Clock cycles ClearFault must be stably high to register a press; >=2.
CNT_W, 8, FaultCount width.

Ports:
Clock  in  1  board clock.
nReset  in  1  board reset, asynchronous, active-low.
Lockup  in  1  M0 LOCKUP, HCLK domain.
ClearFault  in  1  raw push button, active high, asynchronous.
HCLK  out  1  divided SoC clock, 50% duty.
HRESETn  out  1  SoC reset, active low.
Status_Green  out  1  LED green channel.
Status_Red  out  1  LED red channel.
FaultCount  out  CNT_W  saturating count of Lockup rising edges.

Behaviour:
- Interface: reset nReset, asynchronous, active-low; clock Clock. All state is clocked on posedge Clock only.
- On nReset low, immediately:
  - HCLK=0, HRESETn=0, FaultCount=0.
  - Status_Green=1, Status_Red=1 (orange).
  - All counters, synchronisers and the fault latch are cleared.
- Divider:
  - div_cnt counts 0..CLK_DIV/2-1 and wraps.
  - HCLK toggles on the Clock edge where div_cnt==CLK_DIV/2-1.
  - First HCLK rise occurs CLK_DIV/2 Clock cycles after reset release.
  - Runs during the reset stretch.
- Reset sequencer:
  - nReset release passes through a 2-flop synchroniser; rst_sync goes high on the 2nd Clock edge after release.
  - The stretch counter then increments each Clock cycle and saturates at RST_STRETCH.
  - Once saturated, HRESETn goes to 1 on the next Clock edge where HCLK toggles 1->0. HRESETn therefore changes only at HCLK falling edges.
  - running = registered HRESETn.
- Heartbeat:
  - tick counter (HB_COUNT_MSB+1 bits) increments each Clock cycle while running and wraps freely.
  - heartbeat is registered: tick[MSB] & tick[MSB-2] & (tick[DIM_BITS-1:0] < HB_DUTY).
  - HB_DUTY=0 gives heartbeat always 0; HB_DUTY=2^DIM_BITS gives full brightness within the window.
- Lockup and fault counter:
  - Lockup passes through a 2-flop synchroniser to lk_s; a registered lk_d is used for edge detect.
  - A rising edge of lk_s sets fault and increments FaultCount, which saturates at 2^CNT_W-1.
- ClearFault debounce:
  - 2-flop synchroniser, then a stability counter that resets on any low sample.
  - When the counter reaches DEB_CYCLES, emit one clr_pulse (1 Clock cycle).
  - A further pulse requires release (low sample) and a new stable press.
- Fault clear:
  - clr_pulse clears fault and FaultCount only if lk_s==0; otherwise it is ignored.
  - A Lockup rising edge in the same cycle as clr_pulse: set wins and the count increments.
- LED priority, registered, one cycle after inputs:
  1. !running: G=1, R=1.
  2. lk_s==1: G=0, R=1.
  3. fault: G=0, R=tick[MSB] (slow blink).
  4. otherwise: G=heartbeat, R=0.
- Reset mid-operation: nReset low at any time returns every output to its reset value within the same cycle (asynchronous). The full sequence restarts on release.

Test Plan:
- Params CLK_DIV=4, RST_STRETCH=8. Release nReset -> HCLK first rises at Clock edge 2, period 4 Clock cycles; HRESETn rises at the first HCLK fall after 2+8 Clock edges; LED orange until running=1.
- HB_COUNT_MSB=5, DIM_BITS=2, HB_DUTY=1. Run 128 cycles -> Status_Green high only when tick[5]&tick[3] and tick[1:0]==0, one cycle late; Status_Red=0.
- Pulse Lockup high 10 cycles -> FaultCount=1; LED solid red while lk_s=1, then red blinks with tick[MSB]. Three more pulses -> FaultCount=4.
- DEB_CYCLES=4, fault set, Lockup low:
  - ClearFault high 3 cycles -> no clear.
  - ClearFault high 6 cycles -> single clr_pulse, fault=0, FaultCount=0, green heartbeat resumes.
  - Repeat with Lockup held high -> clear ignored.
- CNT_W=2. Apply 5 lockup edges -> FaultCount saturates at 3. Lockup edge coincident with clr_pulse -> fault stays 1, count increments.
- Assert nReset mid-run with fault set -> same-cycle HCLK=0, HRESETn=0, FaultCount=0, LED orange; release -> full sequence repeats.
